// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch path
package cpu_pkg;

    localparam int DEF_ADDR_WIDTH   = 14;
    localparam int DEF_INST_WIDTH   = 32;
    localparam int DEF_RESET_VECTOR = 0;

    localparam logic [DEF_INST_WIDTH-1:0] NOP_WORD = '0;

    // Prefetch queue entry at the default widths; the queue re-declares it at its own widths
    typedef struct packed {
        logic [DEF_INST_WIDTH-1:0] inst;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } prefetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// prefetch_fifo: DEPTH-entry synchronous FIFO with clear, push, pop and occupancy count
module prefetch_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             take;

    assign take  = pop & (count != '0);
    assign rdata = mem[rd_ptr];

    // pointer and count update; clear beats push and pop
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(take);
            count  <= count + (PW+1)'(push) - (PW+1)'(take);
        end

    // storage needs no reset: the count gates everything read out of it
    always_ff @(posedge clock)
        if (push & ~clear) mem[wr_ptr] <= wdata;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: credit-based program-memory prefetcher feeding decode through a small FIFO
module fetch_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH   = DEF_INST_WIDTH,
    parameter int DEPTH        = 4,
    parameter int MEM_LATENCY  = 1,
    parameter int RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic                    clock,
    input  logic                    nreset,
    output logic                    prog_mem_en,
    output logic [ADDR_WIDTH-1:0]   prog_mem_addr,
    input  logic [INST_WIDTH-1:0]   prog_mem_rd_data,
    input  logic                    redirect,
    input  logic [ADDR_WIDTH-1:0]   redirect_addr,
    input  logic                    halt,
    input  logic                    inst_pop,
    output logic                    inst_valid,
    output logic [INST_WIDTH-1:0]   inst_word,
    output logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic [ADDR_WIDTH-1:0]   inst_ret_addr,
    output logic [$clog2(DEPTH):0]  occupancy
);

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    logic                  run;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [MEM_LATENCY-1:0] pipe_v;
    logic [ADDR_WIDTH-1:0] pipe_a [MEM_LATENCY];
    logic [31:0]           inflight;
    logic                  issue;
    entry_t                head;

    // count reads still travelling through program memory
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + 32'(pipe_v[i]);
    end

    // credit check ignores a same-cycle pop, so queued plus in-flight never exceeds DEPTH
    assign issue         = run & ~halt & ~redirect & (32'(occupancy) + inflight < 32'(DEPTH));
    assign prog_mem_en   = issue;
    assign prog_mem_addr = pc;

    // PC steps on issue and jumps on redirect; run keeps the strobe low for the first cycle out of reset
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            run <= 1'b0;
            pc  <= ADDR_WIDTH'(RESET_VECTOR);
        end else begin
            run <= 1'b1;
            pc  <= redirect ? redirect_addr : issue ? pc + 1'b1 : pc;
        end

    // in-flight valid bits: slot 0 takes the new issue, the last slot has its data on the bus
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) pipe_v <= '0;
        else         pipe_v <= redirect ? '0 : MEM_LATENCY'({pipe_v, issue});

    // in-flight addresses travel alongside the valid bits
    always_ff @(posedge clock) begin
        pipe_a[0] <= pc;
        for (int i = 1; i < MEM_LATENCY; i++) pipe_a[i] <= pipe_a[i-1];
    end

    prefetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .nreset (nreset),
        .clear  (redirect),
        .push   (pipe_v[MEM_LATENCY-1]),
        .pop    (inst_pop),
        .wdata  ({prog_mem_rd_data, pipe_a[MEM_LATENCY-1]}),
        .rdata  (head),
        .count  (occupancy)
    );

    assign inst_valid    = occupancy != '0;
    assign inst_word     = inst_valid ? head.inst : INST_WIDTH'(NOP_WORD);
    assign inst_addr     = inst_valid ? head.addr : last_addr;
    assign inst_ret_addr = inst_addr + 1'b1;

    // remember the last head address so the address outputs hold while the queue is empty
    always_ff @(posedge clock or negedge nreset)
        if (!nreset)         last_addr <= '0;
        else if (inst_valid) last_addr <= head.addr;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed checks of the prefetch queue at memory latencies 1 and 3
module tb_fetch_prefetch_queue;

    localparam int AW = 14;
    localparam int IW = 32;
    localparam int OW = 3;

    typedef struct {
        logic          pop;
        logic          redir;
        logic [AW-1:0] raddr;
        logic          en;
        logic [AW-1:0] ma;
        logic          v;
        logic [AW-1:0] ia;
        logic [OW-1:0] oc;
    } vec_t;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    logic          a_en, a_valid, a_redirect = 1'b0, a_halt = 1'b0, a_pop = 1'b0;
    logic [AW-1:0] a_maddr, a_raddr = '0, a_iaddr, a_ret;
    logic [IW-1:0] a_rd, a_word;
    logic [OW-1:0] a_occ;
    logic          b_en, b_valid, b_redirect = 1'b0, b_halt = 1'b0, b_pop = 1'b0;
    logic [AW-1:0] b_maddr, b_raddr = '0, b_iaddr, b_ret;
    logic [IW-1:0] b_rd, b_word;
    logic [OW-1:0] b_occ;

    int nvec = 0;
    int nbad = 0;
    vec_t tv[$];

    function automatic logic [IW-1:0] f(input logic [AW-1:0] a);
        return {2'b11, a, 2'b01, ~a};
    endfunction

    // pipelined ROM models: data for the address presented in cycle t appears in cycle t+latency
    logic [AW-1:0] a_q;
    logic [AW-1:0] b_q [3];
    always @(posedge clock) begin
        a_q    <= a_maddr;
        b_q[0] <= b_maddr;
        b_q[1] <= b_q[0];
        b_q[2] <= b_q[1];
    end
    assign a_rd = f(a_q);
    assign b_rd = f(b_q[2]);

    fetch_prefetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(4), .MEM_LATENCY(1), .RESET_VECTOR(0)) dut_a (
        .clock(clock), .nreset(nreset), .prog_mem_en(a_en), .prog_mem_addr(a_maddr), .prog_mem_rd_data(a_rd),
        .redirect(a_redirect), .redirect_addr(a_raddr), .halt(a_halt), .inst_pop(a_pop), .inst_valid(a_valid),
        .inst_word(a_word), .inst_addr(a_iaddr), .inst_ret_addr(a_ret), .occupancy(a_occ)
    );

    fetch_prefetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(4), .MEM_LATENCY(3), .RESET_VECTOR(0)) dut_b (
        .clock(clock), .nreset(nreset), .prog_mem_en(b_en), .prog_mem_addr(b_maddr), .prog_mem_rd_data(b_rd),
        .redirect(b_redirect), .redirect_addr(b_raddr), .halt(b_halt), .inst_pop(b_pop), .inst_valid(b_valid),
        .inst_word(b_word), .inst_addr(b_iaddr), .inst_ret_addr(b_ret), .occupancy(b_occ)
    );

    task automatic chk(input string t, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", t, act, exp);
        end
    endtask

    task automatic cmp(input string t, input logic en, input logic [AW-1:0] ma, input logic v,
                       input logic [AW-1:0] ia, input logic [AW-1:0] ra, input logic [IW-1:0] w,
                       input logic [OW-1:0] oc, input logic e_en, input logic [AW-1:0] e_ma,
                       input logic e_v, input logic [AW-1:0] e_ia, input logic [OW-1:0] e_oc);
        logic [AW-1:0] e_ra;
        e_ra = e_ia + 1'b1;
        chk({t, " prog_mem_en"}, 32'(en), 32'(e_en));
        chk({t, " prog_mem_addr"}, 32'(ma), 32'(e_ma));
        chk({t, " inst_valid"}, 32'(v), 32'(e_v));
        chk({t, " inst_addr"}, 32'(ia), 32'(e_ia));
        chk({t, " inst_ret_addr"}, 32'(ra), 32'(e_ra));
        chk({t, " inst_word"}, w, e_v ? f(e_ia) : 32'h0);
        chk({t, " occupancy"}, 32'(oc), 32'(e_oc));
    endtask

    task automatic ca(input string t, input logic e_en, input logic [AW-1:0] e_ma, input logic e_v,
                      input logic [AW-1:0] e_ia, input logic [OW-1:0] e_oc);
        cmp(t, a_en, a_maddr, a_valid, a_iaddr, a_ret, a_word, a_occ, e_en, e_ma, e_v, e_ia, e_oc);
    endtask

    task automatic cb(input string t, input logic e_en, input logic [AW-1:0] e_ma, input logic e_v,
                      input logic [AW-1:0] e_ia, input logic [OW-1:0] e_oc);
        cmp(t, b_en, b_maddr, b_valid, b_iaddr, b_ret, b_word, b_occ, e_en, e_ma, e_v, e_ia, e_oc);
    endtask

    task automatic bcyc(input string t, input logic e_en, input logic [AW-1:0] e_ma, input logic e_v,
                        input logic [AW-1:0] e_ia, input logic [OW-1:0] e_oc);
        @(negedge clock);
        cb(t, e_en, e_ma, e_v, e_ia, e_oc);
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic pop, input logic redir, input logic [AW-1:0] raddr,
                                input logic en, input logic [AW-1:0] ma, input logic v,
                                input logic [AW-1:0] ia, input logic [OW-1:0] oc);
        vec_t r;
        r.pop = pop; r.redir = redir; r.raddr = raddr; r.en = en;
        r.ma = ma; r.v = v; r.ia = ia; r.oc = oc;
        return r;
    endfunction

    initial begin
        // latency-1 queue, one entry per cycle after reset release (cycle 0 first)
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b0, 14'd0, 1'b0, 14'd0, 3'd0));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'd0, 1'b0, 14'd0, 3'd0));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'd1, 1'b0, 14'd0, 3'd0));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'd2, 1'b1, 14'd0, 3'd1));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'd3, 1'b1, 14'd0, 3'd2));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b0, 14'd4, 1'b1, 14'd0, 3'd3));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b0, 14'd4, 1'b1, 14'd0, 3'd4));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b0, 14'd4, 1'b1, 14'd0, 3'd4));
        tv.push_back(mk(1'b1, 1'b0, 14'h0, 1'b0, 14'd4, 1'b1, 14'd0, 3'd4));
        tv.push_back(mk(1'b1, 1'b0, 14'h0, 1'b1, 14'd4, 1'b1, 14'd1, 3'd3));
        for (int n = 10; n <= 16; n++)
            tv.push_back(mk(1'b1, 1'b0, 14'h0, 1'b1, AW'(n - 5), 1'b1, AW'(n - 8), 3'd2));
        tv.push_back(mk(1'b1, 1'b1, 14'h200, 1'b0, 14'd12, 1'b1, 14'd9, 3'd2));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'h200, 1'b0, 14'd9, 3'd0));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'h201, 1'b0, 14'd9, 3'd0));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'h202, 1'b1, 14'h200, 3'd1));
        tv.push_back(mk(1'b0, 1'b0, 14'h0, 1'b1, 14'h203, 1'b1, 14'h200, 3'd2));
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        ca("a_reset", 1'b0, 14'h0, 1'b0, 14'h0, 3'd0);
        cb("b_reset", 1'b0, 14'h0, 1'b0, 14'h0, 3'd0);
        @(posedge clock);
        #1;
        nreset = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            a_pop = tv[i].pop;
            a_redirect = tv[i].redir;
            a_raddr = tv[i].raddr;
            @(negedge clock);
            ca($sformatf("a_cycle%0d", i), tv[i].en, tv[i].ma, tv[i].v, tv[i].ia, tv[i].oc);
            @(posedge clock);
            #1;
        end
        a_pop = 1'b0;
        a_redirect = 1'b0;
        // latency-3 queue is full with 0..3; free three credits, then redirect with three reads in flight
        b_pop = 1'b1;
        bcyc("b_full", 1'b0, 14'd4, 1'b1, 14'd0, 3'd4);
        bcyc("b_pop1", 1'b1, 14'd4, 1'b1, 14'd1, 3'd3);
        bcyc("b_pop2", 1'b1, 14'd5, 1'b1, 14'd2, 3'd2);
        b_pop = 1'b0;
        bcyc("b_pop3", 1'b1, 14'd6, 1'b1, 14'd3, 3'd1);
        b_redirect = 1'b1;
        b_raddr = 14'h1234;
        bcyc("b_redirect", 1'b0, 14'd7, 1'b1, 14'd3, 3'd1);
        b_redirect = 1'b0;
        for (int k = 0; k < 4; k++)
            bcyc($sformatf("b_flush%0d", k), 1'b1, AW'(14'h1234 + k), 1'b0, 14'd3, 3'd0);
        bcyc("b_target", 1'b0, 14'h1238, 1'b1, 14'h1234, 3'd1);
        // PC wrap from the top of the address space
        b_redirect = 1'b1;
        b_raddr = 14'h3fff;
        bcyc("b_wrap_redirect", 1'b0, 14'h1238, 1'b1, 14'h1234, 3'd2);
        b_redirect = 1'b0;
        bcyc("b_wrap_issue0", 1'b1, 14'h3fff, 1'b0, 14'h1234, 3'd0);
        bcyc("b_wrap_issue1", 1'b1, 14'h0000, 1'b0, 14'h1234, 3'd0);
        bcyc("b_wrap_issue2", 1'b1, 14'h0001, 1'b0, 14'h1234, 3'd0);
        bcyc("b_wrap_issue3", 1'b1, 14'h0002, 1'b0, 14'h1234, 3'd0);
        b_pop = 1'b1;
        bcyc("b_wrap_head", 1'b0, 14'h0003, 1'b1, 14'h3fff, 3'd1);
        bcyc("b_wrap_next", 1'b1, 14'h0003, 1'b1, 14'h0000, 3'd1);
        b_pop = 1'b0;
        // halt with two reads in flight: both land, no issue until release
        b_redirect = 1'b1;
        b_raddr = 14'h0100;
        bcyc("b_halt_redirect", 1'b0, 14'h0004, 1'b1, 14'h0001, 3'd1);
        b_redirect = 1'b0;
        bcyc("b_halt_issue0", 1'b1, 14'h0100, 1'b0, 14'h0001, 3'd0);
        bcyc("b_halt_issue1", 1'b1, 14'h0101, 1'b0, 14'h0001, 3'd0);
        b_halt = 1'b1;
        bcyc("b_halt0", 1'b0, 14'h0102, 1'b0, 14'h0001, 3'd0);
        bcyc("b_halt1", 1'b0, 14'h0102, 1'b0, 14'h0001, 3'd0);
        bcyc("b_halt_land0", 1'b0, 14'h0102, 1'b1, 14'h0100, 3'd1);
        b_pop = 1'b1;
        bcyc("b_halt_land1", 1'b0, 14'h0102, 1'b1, 14'h0100, 3'd2);
        b_pop = 1'b0;
        b_halt = 1'b0;
        bcyc("b_halt_release", 1'b1, 14'h0102, 1'b1, 14'h0101, 3'd1);
        // redirect during halt moves PC but issues nothing
        b_halt = 1'b1;
        b_redirect = 1'b1;
        b_raddr = 14'h2000;
        bcyc("b_halt_redirect2", 1'b0, 14'h0103, 1'b1, 14'h0101, 3'd1);
        b_redirect = 1'b0;
        bcyc("b_halt_pc", 1'b0, 14'h2000, 1'b0, 14'h0101, 3'd0);
        b_halt = 1'b0;
        bcyc("b_go0", 1'b1, 14'h2000, 1'b0, 14'h0101, 3'd0);
        bcyc("b_go1", 1'b1, 14'h2001, 1'b0, 14'h0101, 3'd0);
        // reset with reads in flight; none of them may surface afterwards
        nreset = 1'b0;
        @(negedge clock);
        ca("a_midreset", 1'b0, 14'h0, 1'b0, 14'h0, 3'd0);
        cb("b_midreset", 1'b0, 14'h0, 1'b0, 14'h0, 3'd0);
        @(posedge clock);
        #1;
        nreset = 1'b1;
        bcyc("b_rst_c0", 1'b0, 14'd0, 1'b0, 14'd0, 3'd0);
        bcyc("b_rst_c1", 1'b1, 14'd0, 1'b0, 14'd0, 3'd0);
        bcyc("b_rst_c2", 1'b1, 14'd1, 1'b0, 14'd0, 3'd0);
        bcyc("b_rst_c3", 1'b1, 14'd2, 1'b0, 14'd0, 3'd0);
        bcyc("b_rst_c4", 1'b1, 14'd3, 1'b0, 14'd0, 3'd0);
        bcyc("b_rst_c5", 1'b0, 14'd4, 1'b1, 14'd0, 3'd1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
